// File: rtl/shake_job_arbiter.sv
// Round-robin arbiter sharing one SHAKE core between NUM_REQ requesters, one whole job per grant.
// Latency: one arbitration cycle per job, then zero-cycle combinational pass-through in both directions.
// Backpressure: the granted side's valid/ready pass straight through; all non-granted requesters see ready low.
module shake_job_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 64,
    localparam int GW         = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_in_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_in_data,
    input  logic [NUM_REQ-1:0]            req_in_last,
    output logic [NUM_REQ-1:0]            req_in_ready,
    output logic [NUM_REQ-1:0]            req_out_valid,
    output logic [DATA_WIDTH-1:0]         req_out_data,
    output logic                          req_out_last,
    input  logic [NUM_REQ-1:0]            req_out_ready,
    output logic                          core_in_valid,
    output logic [DATA_WIDTH-1:0]         core_in_data,
    output logic                          core_in_last,
    input  logic                          core_in_ready,
    input  logic                          core_out_valid,
    input  logic [DATA_WIDTH-1:0]         core_out_data,
    input  logic                          core_out_last,
    output logic                          core_out_ready,
    output logic                          busy,
    output logic [GW-1:0]                 grant_id,
    output logic [15:0]                   job_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [GW-1:0]           ptr;
    logic [GW-1:0]           ptr_inc;
    logic [GW-1:0]           pick;
    logic [GW-1:0]           idx;
    logic                    any_req;
    logic                    start;
    logic                    done;
    logic [DATA_WIDTH-1:0]   in_words [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
        assign in_words[i] = req_in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        pick    = ptr;
        any_req = 1'b0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = GW'((int'(ptr) + k) % NUM_REQ);
            if (req_in_valid[idx]) begin
                pick    = idx;
                any_req = 1'b1;
            end
        end
    end

    assign ptr_inc = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);

    always_comb begin
        state_next     = state;
        start          = 1'b0;
        done           = 1'b0;
        busy           = 1'b0;
        req_in_ready   = '0;
        req_out_valid  = '0;
        core_in_valid  = 1'b0;
        core_in_data   = in_words[grant_id];
        core_in_last   = 1'b0;
        core_out_ready = 1'b0;
        req_out_data   = core_out_data;
        req_out_last   = core_out_last;
        case (state)
            IDLE: begin
                if (any_req) begin
                    start      = 1'b1;
                    state_next = FEED;
                end
            end
            FEED: begin
                busy                   = 1'b1;
                core_in_valid          = req_in_valid[grant_id];
                core_in_last           = req_in_last[grant_id];
                req_in_ready[grant_id] = core_in_ready;
                if (req_in_valid[grant_id] && core_in_ready && req_in_last[grant_id]) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy                    = 1'b1;
                req_out_valid[grant_id] = core_out_valid;
                core_out_ready          = req_out_ready[grant_id];
                if (core_out_valid && req_out_ready[grant_id] && core_out_last) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_id  <= '0;
            ptr       <= '0;
            job_count <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                grant_id <= pick;
            end
            if (done) begin
                ptr       <= ptr_inc;
                job_count <= job_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_shake_job_arbiter.sv
// Directed bench for shake_job_arbiter: single job, pointer wrap, mid-job reset,
// round-robin order, randomised backpressure and job counter wrap.
module tb_shake_job_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_in_valid;
    logic [255:0] req_in_data;
    logic [3:0]   req_in_last;
    logic [3:0]   req_in_ready;
    logic [3:0]   req_out_valid;
    logic [63:0]  req_out_data;
    logic         req_out_last;
    logic [3:0]   req_out_ready;
    logic         core_in_valid;
    logic [63:0]  core_in_data;
    logic         core_in_last;
    logic         core_in_ready;
    logic         core_out_valid;
    logic [63:0]  core_out_data;
    logic         core_out_last;
    logic         core_out_ready;
    logic         busy;
    logic [1:0]   grant_id;
    logic [15:0]  job_count;

    logic [63:0]  in_word [4];
    logic [15:0]  exp_jobs;
    logic [1:0]   exp_ptr;
    int           n_assert = 0;
    int           n_fail   = 0;

    assign req_in_data = {in_word[3], in_word[2], in_word[1], in_word[0]};

    always #5 clk = ~clk;

    shake_job_arbiter #(.NUM_REQ(4), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .req_in_valid(req_in_valid), .req_in_data(req_in_data), .req_in_last(req_in_last),
        .req_in_ready(req_in_ready),
        .req_out_valid(req_out_valid), .req_out_data(req_out_data), .req_out_last(req_out_last),
        .req_out_ready(req_out_ready),
        .core_in_valid(core_in_valid), .core_in_data(core_in_data), .core_in_last(core_in_last),
        .core_in_ready(core_in_ready),
        .core_out_valid(core_out_valid), .core_out_data(core_out_data), .core_out_last(core_out_last),
        .core_out_ready(core_out_ready),
        .busy(busy), .grant_id(grant_id), .job_count(job_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_req_in_ready"}, req_in_ready, 0);
        chk({tag, "_req_out_valid"}, req_out_valid, 0);
        chk({tag, "_core_in_valid"}, core_in_valid, 0);
        chk({tag, "_core_out_ready"}, core_out_ready, 0);
    endtask

    // Caller leaves the arbiter in IDLE with requester g (and possibly others) valid.
    task automatic do_job(input logic [1:0] g, input int n_in, input int n_out, input bit stall);
        int          k;
        int          guard;
        logic        fire;
        logic [3:0]  gbit;
        logic [63:0] w;
        gbit = 4'b0001 << g;
        step();
        core_out_valid = 1'b1;
        core_out_data  = 64'hDEAD_BEEF;
        core_out_last  = 1'b1;
        req_out_ready  = 4'b1111;
        #1;
        chk("grant_id", grant_id, g);
        chk("busy_feed", busy, 1);
        k = 0;
        guard = 0;
        while (k < n_in && guard < 400) begin
            w = 64'hA000 + 64'(g) * 64'h100 + 64'(k);
            in_word[g]     = w;
            req_in_last[g] = (k == n_in - 1);
            if (stall) begin
                core_in_ready   = 1'($urandom_range(0, 1));
                req_in_valid[g] = ($urandom_range(0, 3) != 0);
            end else begin
                core_in_ready   = 1'b1;
                req_in_valid[g] = 1'b1;
            end
            #1;
            chk("feed_core_in_valid", core_in_valid, req_in_valid[g]);
            if (req_in_valid[g]) begin
                chk("feed_core_in_data", core_in_data, w);
                chk("feed_core_in_last", core_in_last, (k == n_in - 1));
            end
            chk("feed_req_in_ready", req_in_ready, core_in_ready ? gbit : 4'b0000);
            chk("feed_core_out_ready", core_out_ready, 0);
            chk("feed_req_out_valid", req_out_valid, 0);
            fire = req_in_valid[g] & core_in_ready;
            step();
            if (fire) k++;
            guard++;
        end
        chk("feed_words_sent", k, n_in);
        k = 0;
        guard = 0;
        while (k < n_out && guard < 400) begin
            w = 64'hD000 + 64'(g) * 64'h100 + 64'(k);
            core_out_data  = w;
            core_out_last  = (k == n_out - 1);
            core_out_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            req_out_ready  = stall ? 4'($urandom_range(0, 15)) : 4'b1111;
            #1;
            chk("drain_req_out_valid", req_out_valid, core_out_valid ? gbit : 4'b0000);
            chk("drain_req_out_data", req_out_data, w);
            chk("drain_req_out_last", req_out_last, (k == n_out - 1));
            chk("drain_core_out_ready", core_out_ready, req_out_ready[g]);
            chk("drain_req_in_ready", req_in_ready, 0);
            chk("drain_busy", busy, 1);
            fire = core_out_valid & req_out_ready[g];
            step();
            if (fire) k++;
            guard++;
        end
        chk("drain_words_taken", k, n_out);
        core_out_valid = 1'b0;
        exp_jobs = exp_jobs + 16'd1;
        exp_ptr  = g + 2'd1;
        #1;
        chk_idle_outputs("post_job");
        chk("job_count", job_count, exp_jobs);
        chk("ptr", dut.ptr, exp_ptr);
    endtask

    initial begin
        rst            = 1'b1;
        req_in_valid   = '0;
        req_in_last    = '0;
        req_out_ready  = '0;
        core_in_ready  = 1'b0;
        core_out_valid = 1'b0;
        core_out_data  = '0;
        core_out_last  = 1'b0;
        for (int i = 0; i < 4; i++) in_word[i] = '0;
        exp_jobs = '0;
        exp_ptr  = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk_idle_outputs("reset");
        chk("reset_grant_id", grant_id, 0);
        chk("reset_job_count", job_count, 0);
        chk("reset_ptr", dut.ptr, 0);

        // Single request from requester 2: 3 input words, 2 digest words.
        req_in_valid = 4'b0100;
        #1;
        chk_idle_outputs("arb_cycle");
        do_job(2'd2, 3, 2, 1'b0);

        // ptr is 3: requesters 0 and 1 together give 0 first, then 1.
        req_in_valid = 4'b0011;
        do_job(2'd0, 1, 1, 1'b0);
        req_in_valid = 4'b0010;
        do_job(2'd1, 2, 1, 1'b0);
        req_in_valid = 4'b0000;

        // Reset after 2 of 4 input words from requester 3.
        req_in_valid  = 4'b1000;
        core_in_ready = 1'b1;
        step();
        #1;
        chk("rst_mid_grant", grant_id, 3);
        for (int k = 0; k < 2; k++) begin
            in_word[3]     = 64'hB000 + 64'(k);
            req_in_last[3] = 1'b0;
            step();
        end
        rst = 1'b1;
        step();
        req_in_valid = 4'b0000;
        #1;
        chk_idle_outputs("rst_mid");
        chk("rst_mid_grant_id", grant_id, 0);
        chk("rst_mid_job_count", job_count, 0);
        rst      = 1'b0;
        exp_jobs = '0;
        exp_ptr  = '0;

        // All four requesters held valid: grants 0,1,2,3,0.
        req_in_valid = 4'b1111;
        do_job(2'd0, 1, 1, 1'b0);
        do_job(2'd1, 1, 1, 1'b0);
        do_job(2'd2, 1, 1, 1'b0);
        do_job(2'd3, 1, 1, 1'b0);
        do_job(2'd0, 1, 1, 1'b0);
        chk("rr_job_count", job_count, 5);

        // Random stalls on both sides with competing requests pending.
        req_in_valid = 4'b1111;
        do_job(2'd1, 4, 3, 1'b1);
        req_in_valid = 4'b1111;
        do_job(2'd2, 3, 2, 1'b1);
        req_in_valid = 4'b0000;
        core_in_ready = 1'b1;

        // Job counter wrap from 0xFFFF.
        step();
        force dut.job_count = 16'hFFFF;
        #1;
        release dut.job_count;
        #1;
        chk("wrap_preload", job_count, 16'hFFFF);
        exp_jobs = 16'hFFFF;
        req_in_valid = 4'b1000;
        do_job(2'd3, 2, 1, 1'b0);
        chk("wrap_job_count", job_count, 16'h0000);
        req_in_valid = 4'b0000;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
